// File: rtl/sumador_adivino_seg_pkg.sv
// Shared constants and the lookahead carry helper for the pipelined adder/subtractor.
package sumador_adivino_seg_pkg;

  // Operation select on the modo input.
  localparam logic MODO_SUMA  = 1'b0;
  localparam logic MODO_RESTA = 1'b1;

  // Carry into bit n of a slice, written as a flat sum of products over g/p/c0
  // so no term depends on another carry (pure lookahead, no ripple).
  // Supports slices up to 32 bits wide.
  function automatic logic lookahead_carry(input logic [31:0] g,
                                           input logic [31:0] p,
                                           input logic        c0,
                                           input int          n);
    logic acc;
    logic pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (g[j] & pp);
      pp  = pp & p[j];
    end
    return acc | (pp & c0);
  endfunction

endpackage

// File: rtl/sumador_adivino_seg_cla_bloque.sv
// Combinational BLK-bit carry-lookahead slice.
module cla_bloque
  import sumador_adivino_seg_pkg::*;
#(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar i = 1; i <= BLK; i++) begin : g_carry
    assign c[i] = lookahead_carry(32'(g), 32'(p), cin, i);
  end

  assign s     = p ^ c[BLK-1:0];
  assign cout  = c[BLK];
  assign c_msb = c[BLK-1];

endmodule

// File: rtl/sumador_adivino_seg.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit slice per stage,
// carry registered between stages, valid/ready on both sides with one global
// advance enable (whole pipeline moves or whole pipeline holds).
module sumador_adivino_seg
  import sumador_adivino_seg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             modo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   res,
  output logic             ovf
);

  localparam int N = WIDTH / BLK;

  logic             en;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en & ~rst;
  assign take     = in_valid & in_ready;

  // The mode is folded into b' and the stage-0 carry-in at entry, so it
  // travels with the operation inside the skewed b' bits and the carry chain.
  assign b_eff = (modo == MODO_SUMA) ? b : ~b;
  assign cin0  = (modo == MODO_RESTA);

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int LO  = k * BLK;
    localparam int REM = WIDTH - LO;
    localparam int SW  = LO + BLK;

    logic [REM-1:0] a_ent;
    logic [REM-1:0] b_ent;
    logic           c_ent;
    logic           v_ent;
    logic [SW-1:0]  s_d;
    logic [BLK-1:0] sl_s;
    logic           sl_cout;
    logic           sl_cmsb;

    logic           valid_q;
    logic           carry_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_head
      assign a_ent = a;
      assign b_ent = b_eff;
      assign c_ent = cin0;
      assign v_ent = take;
      assign s_d   = sl_s;
    end else begin : g_body
      assign a_ent = g_stage[k-1].g_skew.a_q;
      assign b_ent = g_stage[k-1].g_skew.b_q;
      assign c_ent = g_stage[k-1].carry_q;
      assign v_ent = g_stage[k-1].valid_q;
      assign s_d   = {sl_s, g_stage[k-1].s_q};
    end

    cla_bloque #(.BLK(BLK)) u_cla (
      .a     (a_ent[BLK-1:0]),
      .b     (b_ent[BLK-1:0]),
      .cin   (c_ent),
      .s     (sl_s),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
    );

    // Stage register: valid, inter-stage carry and the result bits solved so far.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        s_q     <= '0;
      end else if (en) begin
        valid_q <= v_ent;
        carry_q <= sl_cout;
        s_q     <= s_d;
      end
    end

    if (k < N - 1) begin : g_skew
      logic [REM-BLK-1:0] a_q;
      logic [REM-BLK-1:0] b_q;

      // Upper operand slices wait here until their stage comes up.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_ent[REM-1:BLK];
          b_q <= b_ent[REM-1:BLK];
        end
      end

      // Carry into a slice MSB only matters for the top slice.
      logic unused_cmsb;
      assign unused_cmsb = sl_cmsb;
    end

    if (k == N - 1) begin : g_last
      logic ovf_q;

      // Signed overflow from the top slice: carry into MSB vs carry out of MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= sl_cmsb ^ sl_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].valid_q;
  assign res       = {g_stage[N-1].carry_q, g_stage[N-1].s_q};
  assign ovf       = g_stage[N-1].g_last.ovf_q;

endmodule
